// File: rtl/img_pkg.sv
// Shared types, default geometry and the grayscale weighting used by the
// pixel stream source.
package img_pkg;

    localparam int DATA_WIDTH_DEF = 12;
    localparam int IMG_W_DEF      = 640;
    localparam int IMG_H_DEF      = 480;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    // Channels are zero-extended to 32 bits; the sum carries two extra bits,
    // so the quarter-weighted result always fits the channel width.
    function automatic logic [33:0] gray_of(input logic [31:0] r,
                                            input logic [31:0] g,
                                            input logic [31:0] b);
        logic [33:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum >> 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous skid FIFO with a registered occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/gray_stream_src.sv
// Converts handshaked RGB pixels to gray and streams one raster frame,
// followed by zero lines that drain the downstream line buffers.
module gray_stream_src
    import img_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int IMG_W       = IMG_W_DEF,
    parameter int IMG_H       = IMG_H_DEF,
    parameter int FLUSH_LINES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_pix_valid,
    output logic                  o_pix_ready,
    input  logic [DATA_WIDTH-1:0] i_r,
    input  logic [DATA_WIDTH-1:0] i_g,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_val_valid,
    output logic [DATA_WIDTH-1:0] o_val,
    output logic                  o_sof,
    output logic                  o_eol,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW   = (IMG_H + FLUSH_LINES > 1) ? $clog2(IMG_H + FLUSH_LINES) : 1;

    state_t                state;
    logic [CW-1:0]         in_cnt;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [DATA_WIDTH-1:0] gray;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  line_end;
    logic                  last_frame_pix;
    logic                  last_flush_pix;

    assign gray = DATA_WIDTH'(gray_of(32'(i_r), 32'(i_g), 32'(i_b)));

    assign o_pix_ready    = (state == STREAM) && !fifo_full && (in_cnt < CW'(NPIX));
    assign push           = i_pix_valid && o_pix_ready;
    assign pop            = (state == STREAM) && !fifo_empty;
    assign o_busy         = (state == STREAM) || (state == FLUSH);
    assign line_end       = (x == XW'(IMG_W - 1));
    assign last_frame_pix = line_end && (y == YW'(IMG_H - 1));
    assign last_flush_pix = line_end && (y == YW'(IMG_H + FLUSH_LINES - 1));

    sync_fifo #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .push (push),
        .pop  (pop),
        .din  (gray),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // x/y track the position of the pixel being emitted, so they keep
    // running through the flush lines and o_eol stays line-accurate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            in_cnt      <= '0;
            x           <= '0;
            y           <= '0;
            o_val       <= '0;
            o_val_valid <= 1'b0;
            o_sof       <= 1'b0;
            o_eol       <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_val_valid <= 1'b0;
            o_sof       <= 1'b0;
            o_eol       <= 1'b0;
            o_done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= STREAM;
                        in_cnt <= '0;
                        x      <= '0;
                        y      <= '0;
                    end
                end
                STREAM: begin
                    if (push) in_cnt <= in_cnt + 1'b1;
                    if (pop) begin
                        o_val       <= fifo_dout;
                        o_val_valid <= 1'b1;
                        o_sof       <= (x == '0) && (y == '0);
                        o_eol       <= line_end;
                        if (line_end) begin
                            x <= '0;
                            y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                        if (last_frame_pix) state <= (FLUSH_LINES > 0) ? FLUSH : DONE;
                    end
                end
                FLUSH: begin
                    o_val       <= '0;
                    o_val_valid <= 1'b1;
                    o_eol       <= line_end;
                    if (line_end) begin
                        x <= '0;
                        y <= y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                    if (last_flush_pix) state <= DONE;
                end
                DONE: begin
                    o_done <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_stream_src.sv
// Randomised self-checking bench for gray_stream_src on a 4x3 frame with
// two flush lines, checked against a queue-based model of the frame.
module tb_gray_stream_src;

    localparam int DW   = 12;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int FL   = 2;
    localparam int NPIX = W * H;
    localparam int NOUT = W * (H + FL);

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic          i_pix_valid;
    logic          o_pix_ready;
    logic [DW-1:0] i_r;
    logic [DW-1:0] i_g;
    logic [DW-1:0] i_b;
    logic          o_val_valid;
    logic [DW-1:0] o_val;
    logic          o_sof;
    logic          o_eol;
    logic          o_busy;
    logic          o_done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [DW-1:0] acc_q[$];
    int            acc_cyc[$];
    logic [DW-1:0] out_val[$];
    logic          out_sof[$];
    logic          out_eol[$];
    int            out_cyc[$];
    int            done_cyc[$];
    logic [DW-1:0] exp_q[$];
    int            fix_r[$];
    int            fix_g[$];
    int            fix_b[$];

    gray_stream_src #(
        .DATA_WIDTH(DW),
        .IMG_W(W),
        .IMG_H(H),
        .FLUSH_LINES(FL),
        .FIFO_DEPTH(4)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start(i_start),
        .i_pix_valid(i_pix_valid),
        .o_pix_ready(o_pix_ready),
        .i_r(i_r),
        .i_g(i_g),
        .i_b(i_b),
        .o_val_valid(o_val_valid),
        .o_val(o_val),
        .o_sof(o_sof),
        .o_eol(o_eol),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record accepted pixels (as model gray values) and emitted stream
    // events on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (i_pix_valid && o_pix_ready) begin
            acc_q.push_back(DW'((int'(i_r) + 2 * int'(i_g) + int'(i_b)) / 4));
            acc_cyc.push_back(cyc);
        end
        if (o_val_valid) begin
            out_val.push_back(o_val);
            out_sof.push_back(o_sof);
            out_eol.push_back(o_eol);
            out_cyc.push_back(cyc);
        end
        if (o_done) done_cyc.push_back(cyc);
    end

    task automatic clear_logs();
        acc_q.delete();
        acc_cyc.delete();
        out_val.delete();
        out_sof.delete();
        out_eol.delete();
        out_cyc.delete();
        done_cyc.delete();
        fix_r.delete();
        fix_g.delete();
        fix_b.delete();
    endtask

    // Expected stream: accepted grays in order, then FL lines of zeros.
    task automatic build_expected();
        exp_q.delete();
        foreach (acc_q[i]) exp_q.push_back(acc_q[i]);
        for (int i = 0; i < FL * W; i++) exp_q.push_back('0);
    endtask

    task automatic drive_frame(input bit toggle, input bit spurious, input int target);
        int n;
        int budget;
        @(posedge clk); #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (budget = 0; acc_q.size() < target && budget < 200; budget++) begin
            n = acc_q.size();
            i_pix_valid = toggle ? ~budget[0] : 1'b1;
            i_start = spurious && (n == 6);
            if (n < fix_r.size()) begin
                i_r = DW'(fix_r[n]);
                i_g = DW'(fix_g[n]);
                i_b = DW'(fix_b[n]);
            end else begin
                i_r = DW'($urandom_range(0, 4095));
                i_g = DW'($urandom_range(0, 4095));
                i_b = DW'($urandom_range(0, 4095));
            end
            @(posedge clk); #1;
        end
        i_start = 1'b0;
        checks++;
        if (acc_q.size() != target) begin
            errors++;
            $display("[TB] FAIL feed_timeout: accepted %0d required %0d", acc_q.size(), target);
        end
    endtask

    // Keep offering pixels briefly past the frame end, then wait for o_done.
    task automatic finish_frame(input bit spurious);
        int budget;
        for (budget = 0; (done_cyc.size() == 0 || budget < 4) && budget < 100; budget++) begin
            i_pix_valid = (budget < 4);
            i_start = spurious && (out_val.size() == 15);
            @(posedge clk); #1;
        end
        i_pix_valid = 1'b0;
        i_start = 1'b0;
        checks++;
        if (done_cyc.size() == 0) begin
            errors++;
            $display("[TB] FAIL done_timeout: o_done count %0d required 1", done_cyc.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_start = 1'b0;
        i_pix_valid = 1'b0;
        i_r = '0;
        i_g = '0;
        i_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_pix_ready, o_val_valid, o_val, o_sof, o_eol, o_busy, o_done} !== 18'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {o_pix_ready, o_val_valid, o_val, o_sof, o_eol, o_busy, o_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        i_pix_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_pix_ready, o_val_valid, o_busy, o_done} !== 4'd0) begin
            errors++;
            $display("[TB] FAIL idle_outputs: got %b required 0000", {o_pix_ready, o_val_valid, o_busy, o_done});
        end
        i_pix_valid = 1'b0;
    endtask

    task automatic test_basic_frame();
        clear_logs();
        for (int i = 0; i < NPIX; i++) begin
            fix_r.push_back(100);
            fix_g.push_back(100);
            fix_b.push_back(100);
        end
        drive_frame(1'b0, 1'b0, NPIX);
        finish_frame(1'b0);
        build_expected();
        checks++;
        if (out_val.size() != NOUT) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d pixels required %0d", out_val.size(), NOUT);
        end
        for (int i = 0; i < out_val.size() && i < NOUT; i++) begin
            checks++;
            if ({out_val[i], out_sof[i], out_eol[i]} !== {(i < NPIX) ? DW'(100) : DW'(0), i == 0, (i % W) == W - 1}) begin
                errors++;
                $display("[TB] FAIL basic_pix%0d: got val=%0d sof=%b eol=%b required val=%0d sof=%b eol=%b",
                         i, out_val[i], out_sof[i], out_eol[i], (i < NPIX) ? 100 : 0, i == 0, (i % W) == W - 1);
            end
        end
        for (int i = 0; i < NPIX && i < out_cyc.size() && i < acc_cyc.size(); i++) begin
            checks++;
            if (out_cyc[i] != acc_cyc[i] + 2) begin
                errors++;
                $display("[TB] FAIL basic_latency%0d: got %0d cycles required 2", i, out_cyc[i] - acc_cyc[i]);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || out_cyc.size() == 0 || done_cyc[0] != out_cyc[out_cyc.size() - 1] + 1) begin
            errors++;
            $display("[TB] FAIL basic_done: got %0d pulses required 1 pulse one cycle after last zero", done_cyc.size());
        end
    endtask

    task automatic test_arithmetic();
        logic [DW-1:0] want [3];
        want[0] = DW'(4095);
        want[1] = DW'(0);
        want[2] = DW'(4);
        clear_logs();
        fix_r = '{4095, 1, 8};
        fix_g = '{4095, 0, 4};
        fix_b = '{4095, 2, 0};
        drive_frame(1'b0, 1'b0, NPIX);
        finish_frame(1'b0);
        build_expected();
        for (int i = 0; i < 3 && i < out_val.size(); i++) begin
            checks++;
            if (out_val[i] !== want[i]) begin
                errors++;
                $display("[TB] FAIL arith%0d: got %0d required %0d", i, out_val[i], want[i]);
            end
        end
        for (int i = 0; i < NOUT; i++) begin
            checks++;
            if (i >= out_val.size() || out_val[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL arith_stream%0d: got %0d required %0d", i,
                         (i < out_val.size()) ? out_val[i] : DW'(0), exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        drive_frame(1'b0, 1'b0, NPIX);
        finish_frame(1'b0);
        build_expected();
        checks++;
        if (acc_q.size() != NPIX) begin
            errors++;
            $display("[TB] FAIL bp_accepts: got %0d required %0d", acc_q.size(), NPIX);
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] != acc_cyc[0] + i) begin
                errors++;
                $display("[TB] FAIL bp_ready_gap%0d: got cycle %0d required %0d", i, acc_cyc[i], acc_cyc[0] + i);
            end
        end
        checks++;
        if (o_pix_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_ready_after: got %b required 0", o_pix_ready);
        end
        for (int i = 0; i < NOUT; i++) begin
            checks++;
            if (i >= out_val.size() || {out_val[i], out_eol[i]} !== {exp_q[i], (i % W) == W - 1}) begin
                errors++;
                $display("[TB] FAIL bp_stream%0d: got %0d required %0d", i,
                         (i < out_val.size()) ? out_val[i] : DW'(0), exp_q[i]);
            end
        end
    endtask

    task automatic test_bubbles();
        clear_logs();
        drive_frame(1'b1, 1'b0, NPIX);
        finish_frame(1'b0);
        build_expected();
        for (int i = 0; i < NOUT; i++) begin
            checks++;
            if (i >= out_val.size() || {out_val[i], out_sof[i], out_eol[i]} !== {exp_q[i], i == 0, (i % W) == W - 1}) begin
                errors++;
                $display("[TB] FAIL bubble_pix%0d: got %0d required %0d", i,
                         (i < out_val.size()) ? out_val[i] : DW'(0), exp_q[i]);
            end
        end
        for (int i = 0; i < NPIX && i < out_cyc.size() && i < acc_cyc.size(); i++) begin
            checks++;
            if (out_cyc[i] != acc_cyc[i] + 2) begin
                errors++;
                $display("[TB] FAIL bubble_latency%0d: got %0d cycles required 2", i, out_cyc[i] - acc_cyc[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        drive_frame(1'b0, 1'b0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_pix_ready, o_val_valid, o_val, o_sof, o_eol, o_busy, o_done} !== 18'd0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got %h required 0",
                     {o_pix_ready, o_val_valid, o_val, o_sof, o_eol, o_busy, o_done});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cyc.size() != 0 || o_pix_ready !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle: got done=%0d ready=%b busy=%b required 0 0 0",
                     done_cyc.size(), o_pix_ready, o_busy);
        end
        i_pix_valid = 1'b0;
        clear_logs();
        drive_frame(1'b0, 1'b0, NPIX);
        finish_frame(1'b0);
        build_expected();
        for (int i = 0; i < NOUT; i++) begin
            checks++;
            if (i >= out_val.size() || {out_val[i], out_sof[i]} !== {exp_q[i], i == 0}) begin
                errors++;
                $display("[TB] FAIL restart_pix%0d: got %0d required %0d", i,
                         (i < out_val.size()) ? out_val[i] : DW'(0), exp_q[i]);
            end
        end
        checks++;
        if (done_cyc.size() != 1) begin
            errors++;
            $display("[TB] FAIL restart_done: got %0d pulses required 1", done_cyc.size());
        end
    endtask

    task automatic test_spurious_start();
        clear_logs();
        drive_frame(1'b0, 1'b1, NPIX);
        finish_frame(1'b1);
        build_expected();
        checks++;
        if (out_val.size() != NOUT || acc_q.size() != NPIX) begin
            errors++;
            $display("[TB] FAIL spur_count: got %0d out %0d in required %0d out %0d in",
                     out_val.size(), acc_q.size(), NOUT, NPIX);
        end
        for (int i = 0; i < NOUT && i < out_val.size(); i++) begin
            checks++;
            if ({out_val[i], out_sof[i], out_eol[i]} !== {exp_q[i], i == 0, (i % W) == W - 1}) begin
                errors++;
                $display("[TB] FAIL spur_pix%0d: got val=%0d sof=%b eol=%b required val=%0d", i,
                         out_val[i], out_sof[i], out_eol[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spur_done: got %0d pulses busy=%b required 1 pulse busy=0", done_cyc.size(), o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_arithmetic();
        test_backpressure();
        test_bubbles();
        test_reset_mid_frame();
        test_spurious_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
